// File: rtl/sar_search.sv
// Successive-approximation search: recovers the comparator's `a` operand one bit per
// cycle by driving trial values on `b` and watching the `a < trial` flag.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic {
        IDLE = 1'b0,
        TEST = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] kept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            mask_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // A set lt means the trial overshot, so the bit under test is dropped.
    always_comb begin
        kept     = lt ? (trial_q & ~mask_q) : trial_q;
        state_d  = state_q;
        trial_d  = trial_q;
        mask_d   = mask_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    trial_d = MSB_ONLY;
                    mask_d  = MSB_ONLY;
                    state_d = TEST;
                end
            end
            TEST: begin
                if (mask_q == LSB_ONLY) begin
                    result_d = kept;
                    done_d   = 1'b1;
                    trial_d  = '0;
                    mask_d   = '0;
                    state_d  = IDLE;
                end else begin
                    trial_d = kept | (mask_q >> 1);
                    mask_d  = mask_q >> 1;
                end
            end
            default: begin
                state_d = IDLE;
                trial_d = '0;
                mask_d  = '0;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = (state_q == TEST);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search at WIDTH=4 with a behavioural less-than comparator;
// a scoreboard queue holds the expected result and completion cycle of every search.
module tb_sar_search;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             go;
    logic             lt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_val;

    int   cyc;
    int   pass_count;
    int   total_count;
    exp_t sb[$];

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .lt     (lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Comparator standing in for the calculator's comp instance: a < b.
    assign lt = (a_val < trial);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", int'(result), int'(e.res));
                checkOutput("done_latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [15:0] trials,
                                 input bit check_trace);
        exp_t e;
        a_val = a;
        go    = 1'b1;
        e.res = a;
        e.cyc = cyc + 5;
        sb.push_back(e);
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (check_trace) begin
                checkOutput($sformatf("trial_step%0d", i), int'(trial), int'(trials[15-4*i -: 4]));
                checkOutput($sformatf("busy_step%0d", i), int'(busy), 1);
            end
            @(negedge clk);
        end
        if (check_trace) begin
            checkOutput("busy_after", int'(busy), 0);
            checkOutput("trial_after", int'(trial), 0);
            checkOutput("done_after", int'(done), 1);
        end
    endtask

    initial begin
        exp_t e;
        pass_count  = 0;
        total_count = 0;
        rst   = 1'b1;
        go    = 1'b0;
        a_val = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_trial", int'(trial), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_result", int'(result), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] a=9 trace");
        applyStimulus(4'd9, 16'h8CA9, 1'b1);
        @(negedge clk);
        checkOutput("done_pulse_width", int'(done), 0);

        $display("[TB] boundaries");
        applyStimulus(4'd0, 16'h8421, 1'b1);
        @(negedge clk);
        applyStimulus(4'd15, 16'h8CEF, 1'b1);
        @(negedge clk);

        $display("[TB] sweep");
        for (int a = 0; a < 16; a++) begin
            applyStimulus(4'(a), 16'h0000, 1'b0);
            @(negedge clk);
        end

        $display("[TB] go held high, a=5");
        a_val = 4'd5;
        go    = 1'b1;
        e.res = 4'd5;
        e.cyc = cyc + 5;
        sb.push_back(e);
        @(negedge clk);
        checkOutput("held_trial0", int'(trial), 8);
        @(negedge clk);
        checkOutput("held_trial1", int'(trial), 4);
        @(negedge clk);
        checkOutput("held_trial2", int'(trial), 6);
        @(negedge clk);
        checkOutput("held_trial3", int'(trial), 5);
        @(negedge clk);
        checkOutput("held_done", int'(done), 1);
        e.res = 4'd5;
        e.cyc = cyc + 5;
        sb.push_back(e);
        @(negedge clk);
        checkOutput("held_restart_trial", int'(trial), 8);
        checkOutput("held_restart_busy", int'(busy), 1);
        go = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);

        $display("[TB] async reset mid-search");
        a_val = 4'd6;
        go    = 1'b1;
        e.res = 4'd6;
        e.cyc = cyc + 5;
        sb.push_back(e);
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        void'(sb.pop_back());
        #1;
        checkOutput("arst_trial", int'(trial), 0);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_done", int'(done), 0);
        checkOutput("arst_mask", int'(dut.mask_q), 0);
        checkOutput("arst_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("arst_no_done", int'(done), 0);
        applyStimulus(4'd6, 16'h8467, 1'b1);
        @(negedge clk);

        $display("[TB] back-to-back a=3 then a=12");
        applyStimulus(4'd3, 16'h8423, 1'b1);
        applyStimulus(4'd12, 16'h8CED, 1'b1);
        repeat (3) @(negedge clk);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
